carrier_update_ctrl: RTL

//  Shadow-register update controller for N_CH carrier_gen_16bits channels. Host writes

---
 rtl/carrier_update_ctrl_pkg.sv | 20 ++
 rtl/carrier_shadow_bank.sv | 64 ++++++
 rtl/carrier_update_ctrl.sv | 137 +++++++++++++
 3 files changed

// File: rtl/carrier_update_ctrl_pkg.sv
// Shared types for the carrier shadow-register update controller:
// carrier mode enums, host write selectors, commit modes and FSM states.
package carrier_update_ctrl_pkg;

    localparam int DATA_W = 16;
    localparam int MODE_W = 2;

    // Bit positions of the mode fields inside a MODES write word
    localparam int MODES_CNT_LSB  = 0;
    localparam int MODES_MASK_LSB = 2;

    typedef enum logic [1:0] {COUNT_UP, COUNT_DOWN, COUNT_UPDOWN, COUNT_RSVD} _count_mode;
    typedef enum logic [1:0] {MASK_NONE, MASK_ZERO, MASK_PERIOD, MASK_BOTH}   _mask_mode;
    typedef enum logic       {PWM_OFF, PWM_ON}                                _pwm_onoff;

    typedef enum logic [1:0] {WR_PERIOD, WR_INIT_CARR, WR_MODES, WR_RSVD} _wr_sel;
    typedef enum logic       {COMMIT_IMMEDIATE, COMMIT_AT_SYNC}            _commit_mode;
    typedef enum logic [1:0] {ST_OFF, ST_RUN, ST_WAIT}                     _ctrl_state;

endpackage

// File: rtl/carrier_shadow_bank.sv
// One channel's shadow/active register pair. A load copies the shadow, including
// any write accepted on the same edge, into the active registers.
module carrier_shadow_bank
    import carrier_update_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  _wr_sel            wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              load,
    output logic [DATA_W-1:0] period,
    output logic [DATA_W-1:0] init_carr,
    output _count_mode        count_mode,
    output _mask_mode         mask_mode
);

    logic [DATA_W-1:0] sh_period, sh_init, nx_period, nx_init;
    _count_mode        sh_cnt, nx_cnt;
    _mask_mode         sh_mask, nx_mask;

    always_comb begin
        nx_period = sh_period;
        nx_init   = sh_init;
        nx_cnt    = sh_cnt;
        nx_mask   = sh_mask;
        if (wr_en) begin
            case (wr_sel)
                WR_PERIOD:    nx_period = wr_data;
                WR_INIT_CARR: nx_init   = wr_data;
                WR_MODES: begin
                    nx_cnt  = _count_mode'(wr_data[MODES_CNT_LSB +: MODE_W]);
                    nx_mask = _mask_mode'(wr_data[MODES_MASK_LSB +: MODE_W]);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_period  <= '0;
            sh_init    <= '0;
            sh_cnt     <= COUNT_UP;
            sh_mask    <= MASK_NONE;
            period     <= '0;
            init_carr  <= '0;
            count_mode <= COUNT_UP;
            mask_mode  <= MASK_NONE;
        end else begin
            sh_period <= nx_period;
            sh_init   <= nx_init;
            sh_cnt    <= nx_cnt;
            sh_mask   <= nx_mask;
            if (load) begin
                period     <= nx_period;
                init_carr  <= nx_init;
                count_mode <= nx_cnt;
                mask_mode  <= nx_mask;
            end
        end
    end

endmodule

// File: rtl/carrier_update_ctrl.sv
// Atomic shadow-to-active commit controller for N_CH carrier channels, with
// immediate or sync-aligned commits, sync-wait timeout and run/stop sequencing.
module carrier_update_ctrl
    import carrier_update_ctrl_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int TO_W = 20
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(N_CH)-1:0]  wr_ch,
    input  _wr_sel                   wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     commit_req,
    input  _commit_mode              commit_mode,
    input  logic                     sync_event,
    input  logic                     run,
    output logic [N_CH*DATA_W-1:0]   period,
    output logic [N_CH*DATA_W-1:0]   init_carr,
    output _count_mode [N_CH-1:0]    count_mode,
    output _mask_mode  [N_CH-1:0]    mask_mode,
    output _pwm_onoff  [N_CH-1:0]    pwm_onoff,
    output logic                     commit_busy,
    output logic                     commit_done,
    output logic                     commit_err
);

    localparam int CH_W = $clog2(N_CH);

    _ctrl_state      state, state_nx;
    _pwm_onoff       pwm, pwm_nx;
    logic [TO_W-1:0] cnt, cnt_nx;
    logic            load, done_nx, err_nx, wr_acc;

    assign wr_ready    = (state != ST_WAIT);
    assign commit_busy = (state == ST_WAIT);
    assign wr_acc      = wr_valid & wr_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_OFF;
        else       state <= state_nx;
    end

    // Stop always wins; a start load swallows a coincident commit without error.
    always_comb begin
        state_nx = state;
        pwm_nx   = pwm;
        cnt_nx   = cnt;
        load     = 1'b0;
        done_nx  = 1'b0;
        err_nx   = 1'b0;
        case (state)
            ST_OFF: begin
                if (run) begin
                    load     = 1'b1;
                    pwm_nx   = PWM_ON;
                    state_nx = ST_RUN;
                end else if (commit_req) begin
                    if (commit_mode == COMMIT_IMMEDIATE) begin
                        load    = 1'b1;
                        done_nx = 1'b1;
                    end else begin
                        err_nx = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (!run) begin
                    pwm_nx   = PWM_OFF;
                    state_nx = ST_OFF;
                    err_nx   = commit_req;
                end else if (commit_req) begin
                    if (commit_mode == COMMIT_IMMEDIATE) begin
                        load    = 1'b1;
                        done_nx = 1'b1;
                    end else begin
                        cnt_nx   = '0;
                        state_nx = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!run) begin
                    pwm_nx   = PWM_OFF;
                    state_nx = ST_OFF;
                    err_nx   = 1'b1;
                end else begin
                    err_nx = commit_req;
                    if (sync_event) begin
                        load     = 1'b1;
                        done_nx  = 1'b1;
                        state_nx = ST_RUN;
                    end else if (&cnt) begin
                        err_nx   = 1'b1;
                        state_nx = ST_RUN;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                    end
                end
            end
            default: state_nx = ST_OFF;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pwm         <= PWM_OFF;
            cnt         <= '0;
            commit_done <= 1'b0;
            commit_err  <= 1'b0;
        end else begin
            pwm         <= pwm_nx;
            cnt         <= cnt_nx;
            commit_done <= done_nx;
            commit_err  <= err_nx;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        carrier_shadow_bank u_bank (
            .clk        (clk),
            .reset      (reset),
            .wr_en      (wr_acc && (wr_ch == CH_W'(i))),
            .wr_sel     (wr_sel),
            .wr_data    (wr_data),
            .load       (load),
            .period     (period[i*DATA_W +: DATA_W]),
            .init_carr  (init_carr[i*DATA_W +: DATA_W]),
            .count_mode (count_mode[i]),
            .mask_mode  (mask_mode[i])
        );
        assign pwm_onoff[i] = pwm;
    end

endmodule
